bypass_scoreboard: RTL

Parametrised operand-bypass scoreboard for the in-order pipeline, replacing the fixed set of per-stage forwarders and their stall-time "copy" registers with one structure. It holds a shift register of in-flight register writers, one entry per post-decode stage. Each entry keeps its destination and result while its stage is stalled. The block answers any number of source-operand lookups per cycle with hit, data, or a must-stall indication. It sits beside the hazard unit, between decode/execute issue and regfile writeback.

---
 rtl/bypass_scoreboard_if.sv | 36 +++
 rtl/bypass_scoreboard.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bypass_scoreboard_if.sv
// Pipeline <-> bypass scoreboard bundle: issue, stage control, load return, operand lookups.
// The master side is the pipeline/hazard unit; the slave side is the scoreboard.
interface bypass_scoreboard_if #(
    parameter int unsigned NSTAGES    = 3,
    parameter int unsigned XLEN       = 64,
    parameter int unsigned READ_PORTS = 2
);
    logic                                issue_valid;
    logic                                issue_regwrite;
    logic [4:0]                          issue_dst;
    logic                                issue_late;
    logic [XLEN-1:0]                     issue_data;
    logic [NSTAGES-1:0]                  stage_stall;
    logic [NSTAGES-1:0]                  flush;
    logic                                ld_valid;
    logic [XLEN-1:0]                     ld_data;
    logic [READ_PORTS-1:0][4:0]          rs;
    logic [READ_PORTS-1:0]               fwd_hit;
    logic [READ_PORTS-1:0][XLEN-1:0]     fwd_data;
    logic [READ_PORTS-1:0]               fwd_stall;
    logic                                any_stall;
    logic [31:0]                         stat_hits;
    logic [31:0]                         stat_stalls;

    modport master (
        output issue_valid, issue_regwrite, issue_dst, issue_late, issue_data,
        output stage_stall, flush, ld_valid, ld_data, rs,
        input  fwd_hit, fwd_data, fwd_stall, any_stall, stat_hits, stat_stalls
    );

    modport slave (
        input  issue_valid, issue_regwrite, issue_dst, issue_late, issue_data,
        input  stage_stall, flush, ld_valid, ld_data, rs,
        output fwd_hit, fwd_data, fwd_stall, any_stall, stat_hits, stat_stalls
    );
endinterface

// File: rtl/bypass_scoreboard.sv
// Operand-bypass scoreboard: shift register of in-flight register writers answering lookups.
// Define BYPASS_STATS_EN to build the saturating hit/stall statistics counters.
module bypass_scoreboard #(
    parameter int unsigned NSTAGES    = 3,
    parameter int unsigned XLEN       = 64,
    parameter int unsigned READ_PORTS = 2,
    parameter int unsigned LOAD_STAGE = 1
) (
    input  logic               clk,
    input  logic               reset,
    bypass_scoreboard_if.slave bus
);
    localparam int unsigned REG_W = 5;

    logic [NSTAGES-1:0] valid_q, valid_d;
    logic [NSTAGES-1:0] ready_q, ready_d;
    logic [REG_W-1:0]   dst_q  [NSTAGES];
    logic [REG_W-1:0]   dst_d  [NSTAGES];
    logic [XLEN-1:0]    data_q [NSTAGES];
    logic [XLEN-1:0]    data_d [NSTAGES];

    logic [NSTAGES-1:0] eff_ready;
    logic [XLEN-1:0]    eff_data [NSTAGES];
    logic               ld_cap;
    logic               issue_en;

    // Entry contents with this edge's load return merged in; holds and shifts both use it
    always_comb begin
        ld_cap    = bus.ld_valid && valid_q[LOAD_STAGE] && !ready_q[LOAD_STAGE]
                    && !bus.flush[LOAD_STAGE];
        eff_ready = ready_q;
        eff_data  = data_q;
        if (ld_cap) begin
            eff_ready[LOAD_STAGE] = 1'b1;
            eff_data[LOAD_STAGE]  = bus.ld_data;
        end
    end

    assign issue_en = bus.issue_valid && bus.issue_regwrite && (bus.issue_dst != '0);

    // Per-stage next state: flush, then hold, then bubble or advance
    always_comb begin
        valid_d = valid_q;
        ready_d = eff_ready;
        dst_d   = dst_q;
        data_d  = eff_data;

        if (bus.flush[0]) begin
            valid_d[0] = 1'b0;
            ready_d[0] = 1'b0;
        end else if (!bus.stage_stall[0]) begin
            if (issue_en) begin
                valid_d[0] = 1'b1;
                dst_d[0]   = bus.issue_dst;
                ready_d[0] = !bus.issue_late;
                data_d[0]  = bus.issue_late ? '0 : bus.issue_data;
            end else begin
                valid_d[0] = 1'b0;
                ready_d[0] = 1'b0;
            end
        end

        for (int i = 1; i < int'(NSTAGES); i++) begin
            if (bus.flush[i]) begin
                valid_d[i] = 1'b0;
                ready_d[i] = 1'b0;
            end else if (!bus.stage_stall[i]) begin
                if (bus.stage_stall[i-1]) begin
                    valid_d[i] = 1'b0;
                    ready_d[i] = 1'b0;
                end else begin
                    valid_d[i] = valid_q[i-1];
                    dst_d[i]   = dst_q[i-1];
                    ready_d[i] = eff_ready[i-1];
                    data_d[i]  = eff_data[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            ready_q <= '0;
            for (int i = 0; i < int'(NSTAGES); i++) begin
                dst_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
        end
    end

    // Youngest match wins: scan oldest to youngest so lower indices overwrite
    always_comb begin
        bus.fwd_hit   = '0;
        bus.fwd_stall = '0;
        bus.fwd_data  = '0;
        for (int p = 0; p < int'(READ_PORTS); p++) begin
            for (int i = int'(NSTAGES) - 1; i >= 0; i--) begin
                if (valid_q[i] && (dst_q[i] == bus.rs[p]) && (bus.rs[p] != '0)) begin
                    bus.fwd_hit[p]   = ready_q[i];
                    bus.fwd_stall[p] = !ready_q[i];
                    bus.fwd_data[p]  = ready_q[i] ? data_q[i] : '0;
                end
            end
        end
    end

    assign bus.any_stall = |bus.fwd_stall;

`ifdef BYPASS_STATS_EN
    localparam int unsigned CNT_W = $clog2(READ_PORTS + 1);

    logic [CNT_W-1:0] hit_cnt;
    logic [32:0]      hits_sum;
    logic [31:0]      stat_hits_q, stat_hits_d;
    logic [31:0]      stat_stalls_q, stat_stalls_d;

    // Saturating accumulators
    always_comb begin
        hit_cnt = '0;
        for (int p = 0; p < int'(READ_PORTS); p++) begin
            hit_cnt = hit_cnt + CNT_W'(bus.fwd_hit[p]);
        end
        hits_sum      = 33'(stat_hits_q) + 33'(hit_cnt);
        stat_hits_d   = hits_sum[32] ? '1 : hits_sum[31:0];
        stat_stalls_d = stat_stalls_q;
        if (bus.any_stall && (stat_stalls_q != '1)) begin
            stat_stalls_d = stat_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_hits_q   <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign bus.stat_hits   = stat_hits_q;
    assign bus.stat_stalls = stat_stalls_q;
`else
    assign bus.stat_hits   = '0;
    assign bus.stat_stalls = '0;
`endif

endmodule
